timer_counter: RTL



---
 rtl/timer_counter_if.sv | 11 +
 rtl/timer_counter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/timer_counter_if.sv
// Slot-0 device bus from the system bridge: shared address and write data, the slot
// write strobe, and the slot's combinational read data.
interface timer_counter_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output we, output wdata, input rdata);
    modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/timer_counter.sv
// Programmable down-counting timer with one-shot and auto-reload modes.
// Registers: CTRL {IM, MODE[1:0], EN}, PRESET, COUNT (read-only), decoded from addr[3:2].
module timer_counter (
    input  logic           clk,
    input  logic           reset,
    timer_counter_if.slave bus,
    output logic           irq
);

    typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

    localparam logic [1:0] AddrCtrl   = 2'd0;
    localparam logic [1:0] AddrPreset = 2'd1;
    localparam logic [1:0] AddrCount  = 2'd2;
    localparam logic [1:0] ModeReload = 2'b01;

    state_e      state_q, state_d;
    logic        en_q, en_d;
    logic [1:0]  mode_q, mode_d;
    logic        im_q, im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        pend_q, pend_d;

    logic        ctrl_wr, preset_wr;
    logic        expired, auto_reload;
    logic        load_cnt, dec_cnt, set_pend, int_exit;

    // Only addr[3:2] selects a register; the remaining bits are deliberately ignored.
    logic        unused_addr;
    assign unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};

    assign ctrl_wr     = bus.we && (bus.addr[3:2] == AddrCtrl);
    assign preset_wr   = bus.we && (bus.addr[3:2] == AddrPreset);
    assign expired     = (count_q <= 32'd1);
    assign auto_reload = (mode_q == ModeReload);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (en_q) state_d = StLoad;
            StLoad: state_d = StCnt;
            StCnt: begin
                if (!en_q) begin
                    state_d = StIdle;
                end else if (expired) begin
                    state_d = StInt;
                end
            end
            StInt:  state_d = StIdle;
        endcase
    end

    // FSM outputs: per-state datapath strobes.
    always_comb begin
        load_cnt = 1'b0;
        dec_cnt  = 1'b0;
        set_pend = 1'b0;
        int_exit = 1'b0;
        unique case (state_q)
            StIdle: ;
            StLoad: load_cnt = 1'b1;
            StCnt: begin
                dec_cnt  = en_q;
                set_pend = en_q && expired;
            end
            StInt:  int_exit = 1'b1;
        endcase
    end

    // Register next-state; bus writes are applied last so they override the FSM.
    always_comb begin
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        preset_d = preset_q;
        count_d  = count_q;
        pend_d   = pend_q;

        if (load_cnt) count_d = preset_q;
        if (dec_cnt)  count_d = expired ? 32'd0 : count_q - 32'd1;
        if (set_pend) pend_d = 1'b1;
        if (int_exit) begin
            if (auto_reload) begin
                pend_d = 1'b0;
            end else begin
                en_d = 1'b0;
            end
        end

        if (ctrl_wr) begin
            en_d   = bus.wdata[0];
            mode_d = bus.wdata[2:1];
            im_d   = bus.wdata[3];
            pend_d = 1'b0;
        end
        if (preset_wr) preset_d = bus.wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q     <= 1'b0;
            mode_q   <= 2'b00;
            im_q     <= 1'b0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            pend_q   <= 1'b0;
        end else begin
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        bus.rdata = 32'd0;
        unique case (bus.addr[3:2])
            AddrCtrl:   bus.rdata = {28'd0, im_q, mode_q, en_q};
            AddrPreset: bus.rdata = preset_q;
            AddrCount:  bus.rdata = count_q;
            default:    bus.rdata = 32'd0;
        endcase
    end

    assign irq = im_q && pend_q;

endmodule
